// File: rtl/cov_pkg.sv
// Shared constants and types for the covariance accumulator: channel/pair
// counts, the lane ordering of the upper-triangle products, and the block FSM states.
package cov_pkg;

  localparam int N_CH    = 4;
  localparam int N_PAIRS = 10;

  // Lane order of the upper triangle, row-major: 11,12,13,14,22,23,24,33,34,44
  localparam int L11 = 0;
  localparam int L12 = 1;
  localparam int L13 = 2;
  localparam int L14 = 3;
  localparam int L22 = 4;
  localparam int L23 = 5;
  localparam int L24 = 6;
  localparam int L33 = 7;
  localparam int L34 = 8;
  localparam int L44 = 9;

  localparam int DEF_PW     = 52;
  localparam int DEF_LOG2_N = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/cov_acc_lane.sv
// One covariance lane: AW-bit signed accumulator plus a registered PW-bit
// result equal to the block sum arithmetically shifted right by LOG2_N.
module cov_acc_lane
  import cov_pkg::*;
#(
  parameter int PW     = DEF_PW,
  parameter int LOG2_N = DEF_LOG2_N
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          load,
  input  logic [PW-1:0] prod,
  output logic [PW-1:0] result
);

  localparam int AW = PW + LOG2_N;

  logic [AW-1:0] acc;
  logic [AW-1:0] prod_ext;

  assign prod_ext = {{LOG2_N{prod[PW-1]}}, prod};

  // NOTE: the accumulator is reset as well as cleared on start; a reset in the
  // middle of a block must not leave a partial sum behind for the next block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

  // Taking bits [LOG2_N +: PW] of the AW-bit sum is exactly (acc >>> LOG2_N)
  // truncated to PW bits, i.e. a floor division by the block length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else if (load) begin
      result <= acc[LOG2_N +: PW];
    end
  end

endmodule

// File: rtl/cov_accum.sv
// Block covariance accumulator: sums the 10 per-sample cross-products over
// N_SAMPLES valid samples and emits the averaged upper triangle with a valid pulse.
module cov_accum
  import cov_pkg::*;
#(
  parameter int PW     = DEF_PW,
  parameter int LOG2_N = DEF_LOG2_N
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  prod_valid,
  input  logic [N_PAIRS*PW-1:0] prod_in,
  output logic                  busy,
  output logic [LOG2_N:0]       cnt,
  output logic                  cov_valid,
  output logic [N_PAIRS*PW-1:0] cov_out
);

  localparam int CW        = LOG2_N + 1;
  localparam int N_SAMPLES = 1 << LOG2_N;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_SAMPLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          acc_clr, acc_en, out_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: every output of this block gets a default before the case so that no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    out_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (abort) begin
          acc_clr = 1'b1;
          cnt_d   = '0;
        end else if (start) begin
          acc_clr = 1'b1;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (abort) begin
          acc_clr = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (prod_valid) begin
          acc_en = 1'b1;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        // Abort here discards the finished sums without touching cov_out.
        if (abort) begin
          acc_clr = 1'b1;
          cnt_d   = '0;
        end else begin
          out_load = 1'b1;
          valid_d  = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  for (genvar i = 0; i < N_PAIRS; i++) begin : g_lane
    cov_acc_lane #(
      .PW     (PW),
      .LOG2_N (LOG2_N)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (acc_clr),
      .en     (acc_en),
      .load   (out_load),
      .prod   (prod_in[i*PW +: PW]),
      .result (cov_out[i*PW +: PW])
    );
  end

  assign busy      = (state_q != IDLE);
  assign cnt       = cnt_q;
  assign cov_valid = valid_q;

endmodule

// File: tb/tb_cov_accum.sv
// Scoreboard bench for cov_accum: stimulus pushes the expected averaged block
// and its due cycle; a negedge monitor pops and compares on every cov_valid.
module tb_cov_accum;
  import cov_pkg::*;

  localparam int PW = 52;
  localparam int LOG2_N = 7;
  localparam int VW = N_PAIRS * PW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          prod_valid = 1'b0;
  logic [VW-1:0] prod_in = '0;
  logic          busy;
  logic [LOG2_N:0] cnt;
  logic          cov_valid;
  logic [VW-1:0] cov_out;

  cov_accum #(.PW(PW), .LOG2_N(LOG2_N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .prod_valid (prod_valid),
    .prod_in    (prod_in),
    .busy       (busy),
    .cnt        (cnt),
    .cov_valid  (cov_valid),
    .cov_out    (cov_out)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [VW-1:0] v;
    longint        due;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int pulses = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] rep(input logic [PW-1:0] v);
    return {N_PAIRS{v}};
  endfunction

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (cov_valid) begin
      pulses++;
      check("pulse_len", VW'(prev_valid), '0);
      check("busy_at_pulse", VW'(busy), '0);
      if (q.size() == 0) begin
        check("unexpected_pulse", VW'(cov_valid), '0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("cov_out", cov_out, e.v);
        check("latency_cycle", VW'(cyc), VW'(e.due));
      end
    end
    prev_valid = cov_valid;
  end

  // One block: start pulse, n samples (first, then rest), optional one-cycle
  // gaps with a stray start pulse midway; pushes exp if the block should finish.
  task automatic run_block(input logic [VW-1:0] first, input logic [VW-1:0] rest,
                           input int n, input bit gap, input bit push,
                           input logic [VW-1:0] exp);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", VW'(busy), VW'(1));
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        prod_valid = 1'b0;
        start = (i == 64);
        @(negedge clk);
        start = 1'b0;
      end
      prod_valid = 1'b1;
      prod_in = (i == 0) ? first : rest;
      if (push && i == n - 1) begin
        q.push_back('{v: exp, due: cyc + 2});
        pushed++;
      end
      @(negedge clk);
    end
    prod_valid = 1'b0;
    prod_in = '0;
    check("cnt_after_block", VW'(cnt), VW'(n));
  endtask

  logic [VW-1:0] inc_vec;
  logic [VW-1:0] lane0_neg;

  initial begin
    #3;
    check("rst_busy", VW'(busy), '0);
    check("rst_cnt", VW'(cnt), '0);
    check("rst_valid", VW'(cov_valid), '0);
    check("rst_cov_out", cov_out, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1000 everywhere -> 1000
    run_block(rep(52'd1000), rep(52'd1000), 128, 1'b0, 1'b1, rep(52'd1000));
    repeat (4) @(negedge clk);
    check("busy_idle_1", VW'(busy), '0);

    // -3 everywhere -> -3
    run_block(rep(-52'sd3), rep(-52'sd3), 128, 1'b0, 1'b1, rep(-52'sd3));
    repeat (4) @(negedge clk);

    // single -1 on lane 0 -> floor(-1/128) = -1, others 0
    lane0_neg = '0;
    lane0_neg[L11*PW +: PW] = '1;
    run_block(lane0_neg, '0, 128, 1'b0, 1'b1, lane0_neg);
    repeat (4) @(negedge clk);

    // extremes must not wrap
    run_block(rep(52'h7_FFFF_FFFF_FFFF), rep(52'h7_FFFF_FFFF_FFFF), 128, 1'b0, 1'b1,
              rep(52'h7_FFFF_FFFF_FFFF));
    repeat (4) @(negedge clk);
    run_block(rep(52'h8_0000_0000_0000), rep(52'h8_0000_0000_0000), 128, 1'b0, 1'b1,
              rep(52'h8_0000_0000_0000));
    repeat (4) @(negedge clk);

    // every other cycle, lane i = i+1, stray start mid-block
    for (int i = 0; i < N_PAIRS; i++) inc_vec[i*PW +: PW] = PW'(i + 1);
    run_block(inc_vec, inc_vec, 128, 1'b1, 1'b1, inc_vec);
    repeat (4) @(negedge clk);

    // abort at cnt=60 (with prod_valid high), then a clean block of 5
    run_block(rep(52'd9), rep(52'd9), 60, 1'b0, 1'b0, '0);
    abort = 1'b1;
    prod_valid = 1'b1;
    prod_in = rep(52'd9);
    @(negedge clk);
    abort = 1'b0;
    prod_valid = 1'b0;
    check("abort_busy", VW'(busy), '0);
    check("abort_cnt", VW'(cnt), '0);
    check("abort_holds_cov_out", cov_out, inc_vec);
    repeat (4) @(negedge clk);
    run_block(rep(52'd5), rep(52'd5), 128, 1'b0, 1'b1, rep(52'd5));
    repeat (4) @(negedge clk);

    // asynchronous reset at cnt=100, then a fresh block of 7
    run_block(rep(52'd11), rep(52'd11), 100, 1'b0, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_busy", VW'(busy), '0);
    check("areset_cnt", VW'(cnt), '0);
    check("areset_valid", VW'(cov_valid), '0);
    check("areset_cov_out", cov_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(rep(52'd7), rep(52'd7), 128, 1'b0, 1'b1, rep(52'd7));
    repeat (6) @(negedge clk);

    check("queue_drained", VW'(q.size()), '0);
    check("pulse_count", VW'(pulses), VW'(pushed));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
